// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-drive bundle for alu_arbiter.
//
// Handshake semantics (both request and response channels): a transfer
// happens on a rising clock edge where valid and ready are both high.
// The source holds valid and its payload stable until that edge.
// The sink may drive ready combinationally from valid.
// A valid that has not yet been accepted is never withdrawn.
interface alu_arbiter_if;
    logic        req_valid_0;
    logic        req_valid_1;
    logic        req_ready_0;
    logic        req_ready_1;
    logic [4:0]  req_op_0;
    logic [4:0]  req_op_1;
    logic [31:0] req_x_0;
    logic [31:0] req_y_0;
    logic [31:0] req_x_1;
    logic [31:0] req_y_1;
    logic [4:0]  req_shamt_0;
    logic [4:0]  req_shamt_1;

    logic        rsp_valid_0;
    logic        rsp_valid_1;
    logic        rsp_ready_0;
    logic        rsp_ready_1;
    logic [31:0] rsp_res;
    logic        rsp_v;
    logic        rsp_c_out;
    logic        rsp_zero;
    logic        rsp_err;

    logic [4:0]  alu_opselect;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_res;
    logic        alu_v;
    logic        alu_c_out;
    logic        alu_zero;

    // Arbiter side
    modport slave (
        input  req_valid_0, req_valid_1, req_op_0, req_op_1,
        input  req_x_0, req_y_0, req_x_1, req_y_1, req_shamt_0, req_shamt_1,
        output req_ready_0, req_ready_1,
        output rsp_valid_0, rsp_valid_1, rsp_res, rsp_v, rsp_c_out, rsp_zero, rsp_err,
        input  rsp_ready_0, rsp_ready_1,
        output alu_opselect, alu_x, alu_y, alu_shamt,
        input  alu_res, alu_v, alu_c_out, alu_zero
    );

    // Requester and ALU side
    modport master (
        output req_valid_0, req_valid_1, req_op_0, req_op_1,
        output req_x_0, req_y_0, req_x_1, req_y_1, req_shamt_0, req_shamt_1,
        input  req_ready_0, req_ready_1,
        input  rsp_valid_0, rsp_valid_1, rsp_res, rsp_v, rsp_c_out, rsp_zero, rsp_err,
        output rsp_ready_0, rsp_ready_1,
        input  alu_opselect, alu_x, alu_y, alu_shamt,
        output alu_res, alu_v, alu_c_out, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer for the shared ALU.
// One operation in flight at a time: IDLE (arbitrate) -> EXEC (ALU driven)
// -> RESP (hold result until the granted port consumes it).
// Opselect codes above 5'b10010 are never driven to the ALU.
// Instead they return an error response.
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention.
module alu_arbiter (
    input  logic             clk,
    input  logic             reset_n,
    alu_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state,
    output logic             dbg_last_port
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] OP_MAX = 5'b10010;

    state_t      state;
    logic        last_port;
    logic        port;
    logic        err_q;

    logic        accept;
    logic        grant_1;
    logic [4:0]  win_op;
    logic [31:0] win_x;
    logic [31:0] win_y;
    logic [4:0]  win_shamt;
    logic        win_illegal;

    assign dbg_state     = state;
    assign dbg_last_port = last_port;

    // Pick the winner in IDLE and raise ready for that port only
    always_comb begin
        grant_1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_1 = bus.req_valid_1 & ~bus.req_valid_0;
`else
        grant_1 = bus.req_valid_1 & (~bus.req_valid_0 | ~last_port);
`endif
        accept          = (state == IDLE) & (bus.req_valid_0 | bus.req_valid_1);
        bus.req_ready_0 = accept & ~grant_1;
        bus.req_ready_1 = accept & grant_1;
        win_op          = grant_1 ? bus.req_op_1    : bus.req_op_0;
        win_x           = grant_1 ? bus.req_x_1     : bus.req_x_0;
        win_y           = grant_1 ? bus.req_y_1     : bus.req_y_0;
        win_shamt       = grant_1 ? bus.req_shamt_1 : bus.req_shamt_0;
        win_illegal     = (win_op > OP_MAX);
    end

    // Sequencer: latch winner, drive ALU for one cycle, hold response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            last_port        <= 1'b1;
            port             <= 1'b0;
            err_q            <= 1'b0;
            bus.alu_opselect <= 5'd0;
            bus.alu_x        <= 32'd0;
            bus.alu_y        <= 32'd0;
            bus.alu_shamt    <= 5'd0;
            bus.rsp_valid_0  <= 1'b0;
            bus.rsp_valid_1  <= 1'b0;
            bus.rsp_res      <= 32'd0;
            bus.rsp_v        <= 1'b0;
            bus.rsp_c_out    <= 1'b0;
            bus.rsp_zero     <= 1'b1;
            bus.rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        port      <= grant_1;
                        last_port <= grant_1;
                        err_q     <= win_illegal;
                        // Illegal ops keep the ALU inputs quiet
                        bus.alu_opselect <= win_illegal ? 5'd0  : win_op;
                        bus.alu_x        <= win_illegal ? 32'd0 : win_x;
                        bus.alu_y        <= win_illegal ? 32'd0 : win_y;
                        bus.alu_shamt    <= win_illegal ? 5'd0  : win_shamt;
                        state            <= EXEC;
                    end
                end
                EXEC: begin
                    if (err_q) begin
                        bus.rsp_res   <= 32'd0;
                        bus.rsp_v     <= 1'b0;
                        bus.rsp_c_out <= 1'b0;
                        bus.rsp_zero  <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        bus.rsp_res   <= bus.alu_res;
                        bus.rsp_v     <= bus.alu_v;
                        bus.rsp_c_out <= bus.alu_c_out;
                        bus.rsp_zero  <= bus.alu_zero;
                        bus.rsp_err   <= 1'b0;
                    end
                    bus.rsp_valid_0  <= ~port;
                    bus.rsp_valid_1  <= port;
                    bus.alu_opselect <= 5'd0;
                    bus.alu_x        <= 32'd0;
                    bus.alu_y        <= 32'd0;
                    bus.alu_shamt    <= 5'd0;
                    state            <= RESP;
                end
                RESP: begin
                    // Only the granted port's ready completes the response
                    if (port ? bus.rsp_ready_1 : bus.rsp_ready_0) begin
                        bus.rsp_valid_0 <= 1'b0;
                        bus.rsp_valid_1 <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 32-bit execute-stage ALU. It accepts operation requests from two requesters (port 0: integer pipe, port 1: branch/compare unit) over valid/ready handshakes and grants one at a time, round-robin. It registers the winning operands onto the ALU, captures the ALU result, and returns it to the granted requester over a response handshake. Opselect codes outside the ALU's defined set are rejected with an error response and are never driven to the ALU.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid_0` / `req_valid_1` in 1 each: request valid, per port.
- `req_ready_0` / `req_ready_1` out 1 each: request accepted this cycle, per port.
- `req_op_0` / `req_op_1` in 5 each: ALU opselect, per port.
- `req_x_0`, `req_y_0`, `req_x_1`, `req_y_1` in 32 each: operands.
- `req_shamt_0` / `req_shamt_1` in 5 each: shift amount.
- `rsp_valid_0` / `rsp_valid_1` out 1 each: response valid, per port.
- `rsp_ready_0` / `rsp_ready_1` in 1 each: response consumed, per port.
- `rsp_res` out 32: result, shared by both ports.
- `rsp_v` out 1: overflow flag, shared.
- `rsp_c_out` out 1: carry-out flag, shared.
- `rsp_zero` out 1: zero flag, shared.
- `rsp_err` out 1: illegal opselect flag, shared.
- `alu_opselect` out 5, `alu_x` out 32, `alu_y` out 32, `alu_shamt` out 5: drive the ALU.
- `alu_res` in 32, `alu_v` in 1, `alu_c_out` in 1, `alu_zero` in 1: ALU outputs.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among asserted `req_valid_*`.
  - Assert `req_ready` (combinational) for the winner only.
  - Latch the winner's op, x, y, shamt and its port id; go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - Latched operands drive the ALU.
  - At the clock edge, capture `alu_res`/`alu_v`/`alu_c_out`/`alu_zero` into the response registers; go to RESP.
- **RESP**
  - Assert `rsp_valid` of the granted port only; the shared `rsp_*` outputs stay stable.
  - On `rsp_ready` of that port, go to IDLE.
  - Hold indefinitely otherwise.
  - The other port's `rsp_ready` is ignored.
- **Illegal opselect** (op > 5'b10010):
  - Still follows IDLE→EXEC→RESP.
  - ALU is driven with opselect 5'b00000 and operands 0.
  - Response is `rsp_res`=0, `rsp_v`=0, `rsp_c_out`=0, `rsp_zero`=1, `rsp_err`=1.
  - `rsp_err`=0 for all legal ops.
- **ALU drive outside EXEC:** opselect 5'b00000, x/y/shamt 0, so the ALU inputs are quiet and deterministic.
- **Arbitration** uses a `last_port` register, updated on each grant.
  - Only one port valid: that port wins.
  - Both valid: the port ≠ `last_port` wins.
- Request fields must stay stable while `req_valid` is high and not yet accepted. The block never drops a request that is valid and not accepted.

## Timing
- **Reset** (async assert, sync release):
  - State IDLE, `last_port`=1, so port 0 wins the first contention.
  - All `req_ready`/`rsp_valid`=0.
  - `rsp_res`=0, `rsp_v`/`rsp_c_out`/`rsp_err`=0, `rsp_zero`=1.
  - ALU drive outputs 0.
- **Latency:** accept at edge T; ALU driven during cycle T+1; `rsp_valid` high in cycle T+2.
- **Throughput:** minimum 3 cycles per operation, reached when `rsp_ready` is high on the first RESP cycle.
- A new request can be accepted in the cycle after the RESP handshake (back in IDLE). It is never accepted in the same cycle as the handshake.
- **Reset mid-operation** (EXEC or RESP): the in-flight op is discarded with no response. The requester must reissue.
- **Back-to-back contention:** with both ports continuously valid, grants alternate 0,1,0,1.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority, port 0 always wins contention. `last_port` is still updated but ignored.
  - **Undefined (default):** round-robin as above.

## Test plan
- **Single add:** port 0 requests op 5'b00000, x=5, y=7.
  - `req_ready_0` in cycle T, `rsp_valid_0` at T+2, `rsp_res`=12, `rsp_zero`=0, `rsp_err`=0.
- **Signed overflow:** port 1 requests op 5'b00000, x=32'h7FFFFFFF, y=1.
  - `rsp_res`=32'h80000000, `rsp_v`=1, response on port 1 only.
- **Contention:** both ports continuously request 4 ops.
  - Grant order 0,1,0,1.
  - With `ALU_ARB_FIXED_PRIO_EN`: port 0 gets all 4 grants before port 1.
- **Illegal op:** port 0 requests op 5'b10101.
  - `alu_opselect` stays 0 throughout.
  - Response `rsp_err`=1, `rsp_res`=0, `rsp_zero`=1.
- **Backpressure:** `rsp_ready_0` held low 5 cycles on a SUB of 3−3.
  - `rsp_valid_0` and `rsp_res`=0, `rsp_zero`=1 held stable; `req_ready_1` stays 0 despite `req_valid_1`.
- **Reset mid-op:** `reset_n` low during EXEC.
  - All outputs return to reset values immediately; no `rsp_valid` after release.
  - Next contention grants port 0.
